// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Two-master round-robin arbiter in front of the CPU-side port of the bus
// interface unit. m0 is the CPU data port and m1 is a secondary master, such as
// a DMA or debug engine.
//
// A grant is held for the whole transaction. The granted master's request
// fields are captured into the downstream s_* registers when the grant is
// made. A watchdog ends the transaction with an error if s_ready_i never
// arrives. Every output is a register.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   mX_req_i                 request from master X, held until mX_ready_o
//   mX_mem_w_i               write enable from master X (1 = write)
//   mX_addr_i                address from master X
//   mX_data2bus_i            write data from master X
//   mX_data4bus_o            read data to master X, valid with mX_ready_o
//   mX_ready_o               one-cycle completion pulse to master X
//   mX_err_o                 timeout flag, valid with mX_ready_o
//   s_req_o                  downstream request
//   s_mem_w_o                downstream write enable
//   s_addr_o                 downstream address
//   s_data2bus_o             downstream write data
//   s_data4bus_i             downstream read data
//   s_ready_i                downstream completion
// -----------------------------------------------------------------------------
module bus_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_req_i,
    input  logic        m0_mem_w_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_data2bus_i,
    output logic [31:0] m0_data4bus_o,
    output logic        m0_ready_o,
    output logic        m0_err_o,

    input  logic        m1_req_i,
    input  logic        m1_mem_w_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_data2bus_i,
    output logic [31:0] m1_data4bus_o,
    output logic        m1_ready_o,
    output logic        m1_err_o,

    output logic        s_req_o,
    output logic        s_mem_w_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_data2bus_o,
    input  logic [31:0] s_data4bus_i,
    input  logic        s_ready_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // The last watchdog value that still counts as a normal BUSY cycle.
    localparam logic [TO_W-1:0] WDOG_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] WDOG_ONE  = TO_W'(1);

    state_t          state_r;
    logic            last_grant_r;   // 0 = m0 was served last, 1 = m1
    logic            grant_r;        // owner of the current transaction
    logic [TO_W-1:0] wdog_r;

    logic            s_req_r;
    logic            s_mem_w_r;
    logic [31:0]     s_addr_r;
    logic [31:0]     s_data2bus_r;
    logic [31:0]     m0_data4bus_r;
    logic            m0_ready_r;
    logic            m0_err_r;
    logic [31:0]     m1_data4bus_r;
    logic            m1_ready_r;
    logic            m1_err_r;

    logic            pick_m1_s;

    // Round-robin choice: m1 wins when it requests alone, or on a tie when m0
    // was served last.
    always_comb begin
        pick_m1_s = 1'b0;
        if (m1_req_i && (!m0_req_i || !last_grant_r)) begin
            pick_m1_s = 1'b1;
        end else begin
            pick_m1_s = 1'b0;
        end
    end

    // Arbitration FSM, watchdog and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            last_grant_r  <= 1'b1;
            grant_r       <= 1'b0;
            wdog_r        <= '0;
            s_req_r       <= 1'b0;
            s_mem_w_r     <= 1'b0;
            s_addr_r      <= 32'h0000_0000;
            s_data2bus_r  <= 32'h0000_0000;
            m0_data4bus_r <= 32'h0000_0000;
            m0_ready_r    <= 1'b0;
            m0_err_r      <= 1'b0;
            m1_data4bus_r <= 32'h0000_0000;
            m1_ready_r    <= 1'b0;
            m1_err_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    m0_ready_r <= 1'b0;
                    m0_err_r   <= 1'b0;
                    m1_ready_r <= 1'b0;
                    m1_err_r   <= 1'b0;
                    if (m0_req_i || m1_req_i) begin
                        grant_r      <= pick_m1_s;
                        last_grant_r <= pick_m1_s;
                        wdog_r       <= '0;
                        s_req_r      <= 1'b1;
                        state_r      <= BUSY;
                        if (pick_m1_s) begin
                            s_mem_w_r    <= m1_mem_w_i;
                            s_addr_r     <= m1_addr_i;
                            s_data2bus_r <= m1_data2bus_i;
                        end else begin
                            s_mem_w_r    <= m0_mem_w_i;
                            s_addr_r     <= m0_addr_i;
                            s_data2bus_r <= m0_data2bus_i;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end

                BUSY: begin
                    // A completion beats the watchdog when both happen in the
                    // same cycle.
                    if (s_ready_i) begin
                        s_req_r <= 1'b0;
                        state_r <= DONE;
                        if (grant_r) begin
                            m1_data4bus_r <= s_data4bus_i;
                            m1_ready_r    <= 1'b1;
                            m1_err_r      <= 1'b0;
                        end else begin
                            m0_data4bus_r <= s_data4bus_i;
                            m0_ready_r    <= 1'b1;
                            m0_err_r      <= 1'b0;
                        end
                    end else if (wdog_r == WDOG_LAST) begin
                        s_req_r <= 1'b0;
                        state_r <= DONE;
                        if (grant_r) begin
                            m1_data4bus_r <= 32'h0000_0000;
                            m1_ready_r    <= 1'b1;
                            m1_err_r      <= 1'b1;
                        end else begin
                            m0_data4bus_r <= 32'h0000_0000;
                            m0_ready_r    <= 1'b1;
                            m0_err_r      <= 1'b1;
                        end
                    end else begin
                        wdog_r <= wdog_r + WDOG_ONE;
                    end
                end

                DONE: begin
                    // A dead cycle that gives the requester time to drop req
                    // before the next arbitration.
                    m0_ready_r <= 1'b0;
                    m0_err_r   <= 1'b0;
                    m1_ready_r <= 1'b0;
                    m1_err_r   <= 1'b0;
                    state_r    <= IDLE;
                end

                default: begin
                    s_req_r    <= 1'b0;
                    m0_ready_r <= 1'b0;
                    m0_err_r   <= 1'b0;
                    m1_ready_r <= 1'b0;
                    m1_err_r   <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

    assign s_req_o       = s_req_r;
    assign s_mem_w_o     = s_mem_w_r;
    assign s_addr_o      = s_addr_r;
    assign s_data2bus_o  = s_data2bus_r;
    assign m0_data4bus_o = m0_data4bus_r;
    assign m0_ready_o    = m0_ready_r;
    assign m0_err_o      = m0_err_r;
    assign m1_data4bus_o = m1_data4bus_r;
    assign m1_ready_o    = m1_ready_r;
    assign m1_err_o      = m1_err_r;

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
// Directed bench for bus_arbiter. A table of per-cycle vectors covers
// contention right after reset. Hand-written sequences cover a single read, a
// write during which the requester drops req, a watchdog timeout, and a reset
// issued in the middle of a transaction.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req_i = 1'b0, m0_mem_w_i = 1'b0;
    logic [31:0] m0_addr_i = 32'h0, m0_data2bus_i = 32'h0;
    logic [31:0] m0_data4bus_o;
    logic        m0_ready_o, m0_err_o;
    logic        m1_req_i = 1'b0, m1_mem_w_i = 1'b0;
    logic [31:0] m1_addr_i = 32'h0, m1_data2bus_i = 32'h0;
    logic [31:0] m1_data4bus_o;
    logic        m1_ready_o, m1_err_o;
    logic        s_req_o, s_mem_w_o;
    logic [31:0] s_addr_o, s_data2bus_o;
    logic [31:0] s_data4bus_i = 32'h0;
    logic        s_ready_i = 1'b0;

    int passed = 0;
    int total  = 0;

    bus_arbiter #(.TIMEOUT(TIMEOUT), .TO_W(8)) dut (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req_i), .m0_mem_w_i(m0_mem_w_i), .m0_addr_i(m0_addr_i),
        .m0_data2bus_i(m0_data2bus_i), .m0_data4bus_o(m0_data4bus_o),
        .m0_ready_o(m0_ready_o), .m0_err_o(m0_err_o),
        .m1_req_i(m1_req_i), .m1_mem_w_i(m1_mem_w_i), .m1_addr_i(m1_addr_i),
        .m1_data2bus_i(m1_data2bus_i), .m1_data4bus_o(m1_data4bus_o),
        .m1_ready_o(m1_ready_o), .m1_err_o(m1_err_o),
        .s_req_o(s_req_o), .s_mem_w_o(s_mem_w_o), .s_addr_o(s_addr_o),
        .s_data2bus_o(s_data2bus_o), .s_data4bus_i(s_data4bus_i),
        .s_ready_i(s_ready_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        m0_req;
        logic        m1_req;
        logic        s_ready;
        logic [31:0] s_rdata;
        logic        exp_s_req;
        logic        exp_m0_ready;
        logic        exp_m1_ready;
        logic        exp_mem_w;
        logic [31:0] exp_addr;
        logic [31:0] exp_m0_data;
        logic [31:0] exp_m1_data;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " s_req"},     {31'h0, s_req_o},    32'h0);
        check({tag, " s_mem_w"},   {31'h0, s_mem_w_o},  32'h0);
        check({tag, " s_addr"},    s_addr_o,            32'h0);
        check({tag, " s_data"},    s_data2bus_o,        32'h0);
        check({tag, " m0_ready"},  {31'h0, m0_ready_o}, 32'h0);
        check({tag, " m0_err"},    {31'h0, m0_err_o},   32'h0);
        check({tag, " m0_data"},   m0_data4bus_o,       32'h0);
        check({tag, " m1_ready"},  {31'h0, m1_ready_o}, 32'h0);
        check({tag, " m1_err"},    {31'h0, m1_err_o},   32'h0);
        check({tag, " m1_data"},   m1_data4bus_o,       32'h0);
    endtask

    localparam logic [31:0] A0 = 32'h1000_0000;
    localparam logic [31:0] A1 = 32'h2000_0000;
    localparam logic [31:0] JK = 32'hDEAD_BEEF;
    localparam logic [31:0] D1 = 32'h1111_0001;
    localparam logic [31:0] D2 = 32'h2222_0002;
    localparam logic [31:0] D3 = 32'h1111_0003;
    localparam logic [31:0] D4 = 32'h2222_0004;

    initial begin
        int cnt;
        bit seen;

        // Contention right after reset: both masters request continuously and
        // ready comes immediately. Grants go m0, m1, m0, m1, one every 3 cycles.
        //            m0  m1  rdy data  sreq r0  r1  mw  addr m0d m1d
        vecs[0]  = '{1'b1,1'b1,1'b0,JK, 1'b1,1'b0,1'b0,1'b0,A0,32'h0,32'h0};
        vecs[1]  = '{1'b1,1'b1,1'b1,D1, 1'b0,1'b1,1'b0,1'b0,A0,D1,32'h0};
        vecs[2]  = '{1'b1,1'b1,1'b0,JK, 1'b0,1'b0,1'b0,1'b0,A0,D1,32'h0};
        vecs[3]  = '{1'b1,1'b1,1'b0,JK, 1'b1,1'b0,1'b0,1'b1,A1,D1,32'h0};
        vecs[4]  = '{1'b1,1'b1,1'b1,D2, 1'b0,1'b0,1'b1,1'b1,A1,D1,D2};
        vecs[5]  = '{1'b1,1'b1,1'b0,JK, 1'b0,1'b0,1'b0,1'b1,A1,D1,D2};
        vecs[6]  = '{1'b1,1'b1,1'b0,JK, 1'b1,1'b0,1'b0,1'b0,A0,D1,D2};
        vecs[7]  = '{1'b1,1'b1,1'b1,D3, 1'b0,1'b1,1'b0,1'b0,A0,D3,D2};
        vecs[8]  = '{1'b1,1'b1,1'b0,JK, 1'b0,1'b0,1'b0,1'b0,A0,D3,D2};
        vecs[9]  = '{1'b1,1'b1,1'b0,JK, 1'b1,1'b0,1'b0,1'b1,A1,D3,D2};
        vecs[10] = '{1'b1,1'b1,1'b1,D4, 1'b0,1'b0,1'b1,1'b1,A1,D3,D4};
        vecs[11] = '{1'b0,1'b0,1'b0,JK, 1'b0,1'b0,1'b0,1'b1,A1,D3,D4};
        vecs[12] = '{1'b0,1'b0,1'b0,JK, 1'b0,1'b0,1'b0,1'b1,A1,D3,D4};

        // Reset state
        repeat (3) tick;
        check_all_zero("reset");
        rst = 1'b0;

        // Table-driven contention
        m0_addr_i = A0; m0_mem_w_i = 1'b0; m0_data2bus_i = 32'h0000_00AA;
        m1_addr_i = A1; m1_mem_w_i = 1'b1; m1_data2bus_i = 32'h0000_00BB;
        for (int i = 0; i < 13; i++) begin
            m0_req_i     = vecs[i].m0_req;
            m1_req_i     = vecs[i].m1_req;
            s_ready_i    = vecs[i].s_ready;
            s_data4bus_i = vecs[i].s_rdata;
            tick;
            check($sformatf("v%0d s_req", i),    {31'h0, s_req_o},    {31'h0, vecs[i].exp_s_req});
            check($sformatf("v%0d m0_ready", i), {31'h0, m0_ready_o}, {31'h0, vecs[i].exp_m0_ready});
            check($sformatf("v%0d m1_ready", i), {31'h0, m1_ready_o}, {31'h0, vecs[i].exp_m1_ready});
            check($sformatf("v%0d s_mem_w", i),  {31'h0, s_mem_w_o},  {31'h0, vecs[i].exp_mem_w});
            check($sformatf("v%0d s_addr", i),   s_addr_o,            vecs[i].exp_addr);
            check($sformatf("v%0d m0_data", i),  m0_data4bus_o,       vecs[i].exp_m0_data);
            check($sformatf("v%0d m1_data", i),  m1_data4bus_o,       vecs[i].exp_m1_data);
            check($sformatf("v%0d errs", i),     {30'h0, m0_err_o, m1_err_o}, 32'h0);
        end

        // Single read by m0, ready two cycles into BUSY
        s_data4bus_i = JK;
        m0_req_i = 1'b1; m0_mem_w_i = 1'b0; m0_addr_i = 32'h3000_0010;
        tick;
        check("rd s_req",   {31'h0, s_req_o},   32'h1);
        check("rd s_addr",  s_addr_o,           32'h3000_0010);
        check("rd s_mem_w", {31'h0, s_mem_w_o}, 32'h0);
        tick;
        check("rd early ready", {31'h0, m0_ready_o}, 32'h0);
        s_ready_i = 1'b1; s_data4bus_i = 32'hA5A5_1234;
        tick;
        check("rd m0_ready", {31'h0, m0_ready_o}, 32'h1);
        check("rd m0_data",  m0_data4bus_o,       32'hA5A5_1234);
        check("rd m0_err",   {31'h0, m0_err_o},   32'h0);
        check("rd m1 quiet", {30'h0, m1_ready_o, m1_err_o}, 32'h0);
        check("rd s_req low", {31'h0, s_req_o},   32'h0);
        m0_req_i = 1'b0; s_ready_i = 1'b0; s_data4bus_i = JK;
        tick;
        check("rd pulse end", {31'h0, m0_ready_o}, 32'h0);
        check("rd data hold", m0_data4bus_o,       32'hA5A5_1234);
        tick;

        // m1 write; m1 drops req and changes its fields while BUSY
        m1_req_i = 1'b1; m1_mem_w_i = 1'b1; m1_addr_i = 32'hC000_0004;
        m1_data2bus_i = 32'h0000_0041;
        tick;
        check("wr s_mem_w", {31'h0, s_mem_w_o}, 32'h1);
        check("wr s_addr",  s_addr_o,           32'hC000_0004);
        check("wr s_data",  s_data2bus_o,       32'h0000_0041);
        m1_req_i = 1'b0; m1_mem_w_i = 1'b0; m1_addr_i = 32'hFFFF_FFF0;
        m1_data2bus_i = 32'h1234_5678;
        for (int k = 0; k < 3; k++) begin
            tick;
            check($sformatf("drop%0d s_req", k),   {31'h0, s_req_o},    32'h1);
            check($sformatf("drop%0d s_addr", k),  s_addr_o,            32'hC000_0004);
            check($sformatf("drop%0d s_data", k),  s_data2bus_o,        32'h0000_0041);
            check($sformatf("drop%0d s_mem_w", k), {31'h0, s_mem_w_o},  32'h1);
            check($sformatf("drop%0d m1_ready", k), {31'h0, m1_ready_o}, 32'h0);
        end
        s_ready_i = 1'b1; s_data4bus_i = 32'h7777_0007;
        tick;
        check("wr m1_ready", {31'h0, m1_ready_o}, 32'h1);
        check("wr m1_err",   {31'h0, m1_err_o},   32'h0);
        check("wr m1_data",  m1_data4bus_o,       32'h7777_0007);
        check("wr m0 quiet", {31'h0, m0_ready_o}, 32'h0);
        s_ready_i = 1'b0; s_data4bus_i = JK;
        tick;
        check("wr pulse end", {31'h0, m1_ready_o}, 32'h0);
        tick;
        check("wr no regrant", {31'h0, s_req_o}, 32'h0);

        // Watchdog timeout on an m0 read
        m0_req_i = 1'b1; m0_mem_w_i = 1'b0; m0_addr_i = 32'h4000_0000;
        cnt = 0; seen = 1'b0;
        for (int k = 0; k < 1000 && !seen; k++) begin
            tick;
            if (m0_ready_o) begin
                seen = 1'b1;
            end else if (s_req_o) begin
                cnt++;
            end
        end
        m0_req_i = 1'b0;
        check("to seen",     {31'h0, seen},       32'h1);
        check("to cycles",   cnt,                 TIMEOUT);
        check("to m0_err",   {31'h0, m0_err_o},   32'h1);
        check("to m0_data",  m0_data4bus_o,       32'h0);
        check("to s_req",    {31'h0, s_req_o},    32'h0);
        check("to m1 quiet", {31'h0, m1_ready_o}, 32'h0);
        tick;
        check("to err end",  {30'h0, m0_ready_o, m0_err_o}, 32'h0);
        tick;

        // Reset three cycles into an m0 transaction
        m0_req_i = 1'b1; m0_addr_i = 32'h5000_0000;
        repeat (3) tick;
        check("rb busy", {31'h0, s_req_o}, 32'h1);
        #2;
        rst = 1'b1; s_ready_i = 1'b1; s_data4bus_i = 32'h9999_9999;
        #1;
        check_all_zero("rst mid");
        tick;
        tick;
        check("rst no pulse", {30'h0, m0_ready_o, m1_ready_o}, 32'h0);
        rst = 1'b0; s_ready_i = 1'b0;
        m0_req_i = 1'b1; m1_req_i = 1'b1;
        m0_addr_i = A0; m1_addr_i = A1;
        tick;
        check("post rst s_req", {31'h0, s_req_o}, 32'h1);
        check("post rst tie",   s_addr_o,         A0);
        m0_req_i = 1'b0; m1_req_i = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
